wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
- Write-back/commit end of the MEM/WB pipeline register.
- Consumes the registered WB-stage bundle and selects the write-back value. Owns the 32x32 integer register file, with two combinational read ports and write-to-read bypass for decode.
- Maintains the 64-bit cycle and instret counters, which are readable and writable through the CSR address space.

Parameters:
- XLEN, 32, data/arch width of register file, write-back data and counter halves.
- NUM_REGS, 32, register count; index width is $clog2(NUM_REGS).
- RESET_PC, 32'h0, value driven on commit_pc while in reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_stall  in  1  1 = bubble in WB (no retire, no writes).
- wb_reg_file_we  in  1  register write request.
- wb_reg_file_rd  in  5  destination register.
- wb_reg_file_sel  in  2  write-back source select.
- wb_alu_res  in  XLEN  ALU result.
- wb_data_mem_out  in  XLEN  load data.
- wb_pc_out  in  XLEN  PC of the WB instruction.
- wb_csr_data_out  in  XLEN  old CSR value (for rd).
- wb_csr_we  in  1  CSR write request.
- wb_csr_addr  in  12  CSR address.
- wb_csr_wdata  in  XLEN  CSR write value.
- rs1_addr, rs2_addr  in  5 each  decode read indices.
- rs1_data, rs2_data  out  XLEN each  read data (bypassed).
- csr_raddr  in  12  counter read address.
- csr_rdata  out  XLEN  counter read data.
- csr_hit  out  1  csr_raddr matches a counter CSR.
- commit_valid  out  1  trace: instruction retired last cycle.
- commit_pc, commit_data  out  XLEN each  trace PC and write data.
- commit_rd  out  5  trace destination.

Behaviour:
- Retire condition: retire = ~wb_stall.
  - Register writes and CSR writes are gated by retire.
  - Register write is a no-op when rd = 0.
- Write-back mux (combinational):
  - sel 00 → wb_alu_res.
  - sel 01 → wb_data_mem_out.
  - sel 10 → wb_pc_out + 4, modulo 2^XLEN.
  - sel 11 → wb_csr_data_out.
- Register file:
  - Written on the rising clk edge when retire & wb_reg_file_we & rd != 0.
  - x0 always reads 0.
- Read ports:
  - Combinational.
  - If the read index equals rd, the write is enabled this cycle, and the index is nonzero, return the mux value (same-cycle bypass). Otherwise return the array contents.
- Counters:
  - mcycle is 64 bit and increments every cycle.
  - minstret is 64 bit and increments by 1 on each retire. Full wrap 2^64-1 → 0; the low-half carry propagates to the high half.
- CSR map (read and write):
  - 0xB00 mcycle[31:0], 0xB80 mcycle[63:32].
  - 0xB02 minstret[31:0], 0xB82 minstret[63:32].
  - Read-only aliases: 0xC00/0xC80 cycle, 0xC02/0xC82 instret.
  - Any other address: csr_hit = 0, csr_rdata = 0.
- CSR write (retire & wb_csr_we):
  - Replaces the addressed half with wb_csr_wdata.
  - That cycle's increment is suppressed for the whole written counter; the other half holds.
  - Writes to 0xC** aliases and unmapped addresses are ignored.
- Counter read:
  - Reflects the register value before the current edge; no bypass of the same-cycle CSR write.
- Reset (rst_n low, asynchronous):
  - All registers, mcycle and minstret go to 0.
  - commit_valid = 0, commit_pc = RESET_PC, commit_rd = 0, commit_data = 0.
  - rs1_data/rs2_data read 0 during and after reset until written.
  - Reset mid-operation discards any in-flight write.
  - The first edge after release increments mcycle to 1.

Optional Feature:
- Macro: WB_COMMIT_TRACE_EN.
- Defined: commit_* outputs are registered one cycle after a retire.
  - commit_valid = retire.
  - commit_pc = wb_pc_out.
  - commit_rd = wb_reg_file_we ? rd : 0.
  - commit_data = mux value.
  - On a non-retire cycle commit_valid = 0 and the other commit_* hold.
- Not defined: commit_* ports remain and are held at reset values permanently; no trace flops are synthesized.

Test Plan:
- Reset, then write x5 (sel=00, alu_res=32'hDEADBEEF, no stall) → next cycle rs1_addr=5 reads 32'hDEADBEEF; then write x0 = 32'h1234 → rs2_addr=0 reads 0.
- Same-cycle bypass: write x7 (sel=10, pc_out=32'h100) while rs1_addr=7 → rs1_data = 32'h104 in that same cycle.
- Stall gating: wb_stall=1 with we=1, rd=3, alu_res=32'h55 → x3 unchanged at 0; minstret unchanged; mcycle still advances.
- Counter wrap: CSR write 0xB02=32'hFFFFFFFF, then one retire → 0xB02 reads 0, 0xB82 reads 1; in the write cycle itself minstret does not increment.
- Write to alias 0xC02 = 32'h99 → ignored, instret unchanged. Read csr_raddr=0x300 → csr_hit=0, csr_rdata=0.
- With WB_COMMIT_TRACE_EN: retire a load to x9 (data_mem_out=32'hA5A5A5A5, pc=32'h200) → one cycle later commit_valid=1, commit_pc=32'h200, commit_rd=9, commit_data=32'hA5A5A5A5. Async reset asserted mid-stream → commit_valid=0 immediately.

Source files
------------

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: write-back mux, 32x32 register file with decode bypass, mcycle/minstret CSRs.
// Optional commit trace registers are enabled by defining WB_COMMIT_TRACE_EN.
module wb_commit_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     NUM_REGS = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_stall,
   input  logic            wb_reg_file_we,
   input  logic [4:0]      wb_reg_file_rd,
   input  logic [1:0]      wb_reg_file_sel,
   input  logic [XLEN-1:0] wb_alu_res,
   input  logic [XLEN-1:0] wb_data_mem_out,
   input  logic [XLEN-1:0] wb_pc_out,
   input  logic [XLEN-1:0] wb_csr_data_out,
   input  logic            wb_csr_we,
   input  logic [11:0]     wb_csr_addr,
   input  logic [XLEN-1:0] wb_csr_wdata,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic [11:0]     csr_raddr,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_hit,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,
   output logic [XLEN-1:0] commit_data,
   output logic [4:0]      commit_rd
);

   localparam int unsigned IDXW = $clog2(NUM_REGS);
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [2*XLEN-1:0] CNT_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};

   logic            retire;
   logic            rf_we;
   logic            csr_wr;
   logic [XLEN-1:0] wb_val;
   logic [XLEN-1:0] regs [NUM_REGS];
   logic [2*XLEN-1:0] mcycle;
   logic [2*XLEN-1:0] minstret;

   assign retire = ~wb_stall;
   assign rf_we  = retire & wb_reg_file_we & (wb_reg_file_rd != '0);
   assign csr_wr = retire & wb_csr_we;

   always_comb begin
      wb_val = wb_alu_res;
      unique case (wb_reg_file_sel)
         2'b00: wb_val = wb_alu_res;
         2'b01: wb_val = wb_data_mem_out;
         2'b10: wb_val = wb_pc_out + XLEN'(4);
         2'b11: wb_val = wb_csr_data_out;
         default: wb_val = wb_alu_res;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (rf_we) begin
         regs[wb_reg_file_rd[IDXW-1:0]] <= wb_val;
      end
   end

   // Bypass lets decode see the value retiring this cycle before it lands in the array.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != '0)
         rs1_data = (rf_we && rs1_addr == wb_reg_file_rd) ? wb_val : regs[rs1_addr[IDXW-1:0]];
      if (rs2_addr != '0)
         rs2_data = (rf_we && rs2_addr == wb_reg_file_rd) ? wb_val : regs[rs2_addr[IDXW-1:0]];
   end

   // A CSR write to either half replaces that half and suppresses the whole counter's increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (csr_wr && wb_csr_addr == A_MCYCLE)
            mcycle <= {mcycle[2*XLEN-1:XLEN], wb_csr_wdata};
         else if (csr_wr && wb_csr_addr == A_MCYCLEH)
            mcycle <= {wb_csr_wdata, mcycle[XLEN-1:0]};
         else
            mcycle <= mcycle + CNT_ONE;

         if (csr_wr && wb_csr_addr == A_MINSTRET)
            minstret <= {minstret[2*XLEN-1:XLEN], wb_csr_wdata};
         else if (csr_wr && wb_csr_addr == A_MINSTRETH)
            minstret <= {wb_csr_wdata, minstret[XLEN-1:0]};
         else if (retire)
            minstret <= minstret + CNT_ONE;
      end
   end

   always_comb begin
      csr_hit   = 1'b1;
      csr_rdata = '0;
      unique case (csr_raddr)
         A_MCYCLE,   A_CYCLE:    csr_rdata = mcycle[XLEN-1:0];
         A_MCYCLEH,  A_CYCLEH:   csr_rdata = mcycle[2*XLEN-1:XLEN];
         A_MINSTRET, A_INSTRET:  csr_rdata = minstret[XLEN-1:0];
         A_MINSTRETH, A_INSTRETH: csr_rdata = minstret[2*XLEN-1:XLEN];
         default: begin
            csr_hit   = 1'b0;
            csr_rdata = '0;
         end
      endcase
   end

`ifdef WB_COMMIT_TRACE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_valid <= 1'b0;
         commit_pc    <= RESET_PC;
         commit_rd    <= '0;
         commit_data  <= '0;
      end else begin
         commit_valid <= retire;
         if (retire) begin
            commit_pc   <= wb_pc_out;
            commit_rd   <= wb_reg_file_we ? wb_reg_file_rd : '0;
            commit_data <= wb_val;
         end
      end
   end
`else
   assign commit_valid = 1'b0;
   assign commit_pc    = RESET_PC;
   assign commit_rd    = '0;
   assign commit_data  = '0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Randomized self-checking bench for wb_commit_unit against a behavioural reference model.
module tb_wb_commit_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_stall = 1'b0;
   logic        wb_reg_file_we = 1'b0;
   logic [4:0]  wb_reg_file_rd = '0;
   logic [1:0]  wb_reg_file_sel = '0;
   logic [31:0] wb_alu_res = '0, wb_data_mem_out = '0, wb_pc_out = '0, wb_csr_data_out = '0;
   logic        wb_csr_we = 1'b0;
   logic [11:0] wb_csr_addr = '0;
   logic [31:0] wb_csr_wdata = '0;
   logic [4:0]  rs1_addr = '0, rs2_addr = '0;
   logic [31:0] rs1_data, rs2_data;
   logic [11:0] csr_raddr = 12'hB00;
   logic [31:0] csr_rdata;
   logic        csr_hit;
   logic        commit_valid;
   logic [31:0] commit_pc, commit_data;
   logic [4:0]  commit_rd;

   wb_commit_unit #(.XLEN(32), .NUM_REGS(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
      .wb_reg_file_we(wb_reg_file_we), .wb_reg_file_rd(wb_reg_file_rd),
      .wb_reg_file_sel(wb_reg_file_sel), .wb_alu_res(wb_alu_res),
      .wb_data_mem_out(wb_data_mem_out), .wb_pc_out(wb_pc_out),
      .wb_csr_data_out(wb_csr_data_out), .wb_csr_we(wb_csr_we),
      .wb_csr_addr(wb_csr_addr), .wb_csr_wdata(wb_csr_wdata),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
      .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_data(commit_data), .commit_rd(commit_rd)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // reference state
   logic [31:0] m_regs [32];
   logic [63:0] m_cyc, m_ins;
   logic        m_tv;
   logic [31:0] m_tpc, m_tdata;
   logic [4:0]  m_trd;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] wb_value();
      case (wb_reg_file_sel)
         2'd0: return wb_alu_res;
         2'd1: return wb_data_mem_out;
         2'd2: return wb_pc_out + 32'd4;
         default: return wb_csr_data_out;
      endcase
   endfunction

   function automatic logic [31:0] reg_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (!wb_stall && wb_reg_file_we && a == wb_reg_file_rd) return wb_value();
      return m_regs[a];
   endfunction

   function automatic logic [32:0] csr_read(input logic [11:0] a);
      case (a)
         12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
         12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
         12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
         12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
         default:          return 33'h0;
      endcase
   endfunction

   task automatic model_reset();
      foreach (m_regs[i]) m_regs[i] = '0;
      m_cyc = '0; m_ins = '0;
      m_tv = 1'b0; m_tpc = 32'h0; m_tdata = '0; m_trd = '0;
   endtask

   task automatic check_trace();
`ifdef WB_COMMIT_TRACE_EN
      check("commit_valid", commit_valid, m_tv);
      check("commit_pc", commit_pc, m_tpc);
      check("commit_rd", commit_rd, m_trd);
      check("commit_data", commit_data, m_tdata);
`else
      check("commit_valid", commit_valid, 1'b0);
      check("commit_pc", commit_pc, 32'h0);
      check("commit_rd", commit_rd, 5'd0);
      check("commit_data", commit_data, 32'h0);
`endif
   endtask

   // Called just after a falling edge with inputs already applied; checks, then advances one cycle.
   task automatic cycle();
      logic        ret, wr;
      logic [32:0] cr;
      logic [31:0] v;
      #1;
      check("rs1_data", rs1_data, reg_read(rs1_addr));
      check("rs2_data", rs2_data, reg_read(rs2_addr));
      cr = csr_read(csr_raddr);
      check("csr_hit", csr_hit, cr[32]);
      check("csr_rdata", csr_rdata, cr[31:0]);
      check_trace();
      ret = !wb_stall;
      wr  = ret && wb_csr_we;
      v   = wb_value();
      @(posedge clk);
      if (ret && wb_reg_file_we && wb_reg_file_rd != 0) m_regs[wb_reg_file_rd] = v;
      if (wr && wb_csr_addr == 12'hB00)      m_cyc[31:0]  = wb_csr_wdata;
      else if (wr && wb_csr_addr == 12'hB80) m_cyc[63:32] = wb_csr_wdata;
      else                                   m_cyc = m_cyc + 64'd1;
      if (wr && wb_csr_addr == 12'hB02)      m_ins[31:0]  = wb_csr_wdata;
      else if (wr && wb_csr_addr == 12'hB82) m_ins[63:32] = wb_csr_wdata;
      else if (ret)                          m_ins = m_ins + 64'd1;
      m_tv = ret;
      if (ret) begin
         m_tpc = wb_pc_out; m_tdata = v; m_trd = wb_reg_file_we ? wb_reg_file_rd : 5'd0;
      end
      @(negedge clk);
   endtask

   task automatic set_wb(input logic stall, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] val);
      wb_stall = stall; wb_reg_file_we = we; wb_reg_file_rd = rd; wb_reg_file_sel = sel;
      wb_alu_res = val; wb_data_mem_out = val; wb_pc_out = val; wb_csr_data_out = val;
      wb_csr_we = 1'b0;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      set_wb(1'b0, 1'b0, 5'd0, 2'd0, 32'h0);
      wb_csr_we = 1'b1; wb_csr_addr = a; wb_csr_wdata = d;
   endtask

   initial begin
      logic [11:0] addrs [8];
      addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC02, 12'hC82, 12'h300};
      model_reset();
      rs1_addr = 5'd5; rs2_addr = 5'd0;
      #2;
      check("reset_rs1", rs1_data, 32'h0);
      check("reset_csr", csr_rdata, 32'h0);
      check_trace();
      @(negedge clk);
      rst_n = 1'b1;

      set_wb(1'b0, 1'b1, 5'd5, 2'd0, 32'hDEADBEEF);
      cycle();
      check("mcycle_first", csr_rdata, 32'h1);
      set_wb(1'b0, 1'b1, 5'd0, 2'd0, 32'h1234);
      rs1_addr = 5'd5; rs2_addr = 5'd0;
      #1 check("x5_read", rs1_data, 32'hDEADBEEF);
      cycle();
      check("x0_read", rs2_data, 32'h0);

      set_wb(1'b0, 1'b1, 5'd7, 2'd2, 32'h100);
      rs1_addr = 5'd7;
      #1 check("bypass", rs1_data, 32'h104);
      cycle();

      set_wb(1'b1, 1'b1, 5'd3, 2'd0, 32'h55);
      rs1_addr = 5'd3; csr_raddr = 12'hB02;
      cycle();
      #1 check("stall_x3", rs1_data, 32'h0);

      csr_write(12'hB82, 32'h0);          cycle();
      csr_write(12'hB02, 32'hFFFFFFFF);   cycle();
      set_wb(1'b0, 1'b0, 5'd0, 2'd0, 32'h0);
      #1 check("wr_no_inc", csr_rdata, 32'hFFFFFFFF);
      cycle();
      #1 check("wrap_lo", csr_rdata, 32'h0);
      csr_raddr = 12'hB82;
      #1 check("wrap_hi", csr_rdata, 32'h1);

      csr_write(12'hC02, 32'h99); csr_raddr = 12'hC02; cycle();
      set_wb(1'b1, 1'b0, 5'd0, 2'd0, 32'h0);
      csr_raddr = 12'h300;
      #1 check("unmapped_hit", csr_hit, 1'b0);
      cycle();

      csr_write(12'hB80, 32'hFFFFFFFF); cycle();
      csr_write(12'hB00, 32'hFFFFFFFE); cycle();
      set_wb(1'b0, 1'b1, 5'd9, 2'd1, 32'h200);
      wb_data_mem_out = 32'hA5A5A5A5;
      csr_raddr = 12'hB80;
      cycle();
      set_wb(1'b1, 1'b0, 5'd0, 2'd0, 32'h0);
      cycle();

      for (int i = 0; i < 400; i++) begin
         set_wb(($urandom_range(3) == 0), $urandom_range(1), 5'($urandom), 2'($urandom), $urandom);
         wb_data_mem_out = $urandom; wb_pc_out = $urandom; wb_csr_data_out = $urandom;
         if ($urandom_range(9) == 0) begin
            wb_csr_we = 1'b1; wb_csr_addr = addrs[$urandom_range(7)]; wb_csr_wdata = $urandom;
         end
         rs1_addr = ($urandom_range(2) == 0) ? wb_reg_file_rd : 5'($urandom);
         rs2_addr = 5'($urandom);
         csr_raddr = addrs[$urandom_range(7)];
         cycle();
         if (i == 200) begin
            set_wb(1'b0, 1'b1, 5'd4, 2'd0, 32'h77);
            rs1_addr = 5'd4; rs2_addr = 5'd9; csr_raddr = 12'hB00;
            #2 rst_n = 1'b0;
            #1;
            check("async_valid", commit_valid, 1'b0);
            check("async_csr", csr_rdata, 32'h0);
            check("async_rs2", rs2_data, 32'h0);
            model_reset();
            check_trace();
            @(negedge clk);
            rst_n = 1'b1;
            wb_reg_file_we = 1'b0;
            cycle();
            check("post_reset_x4", rs1_data, 32'h0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
